// File: rtl/buffer_fifo_pkg.sv
// Shared defaults and small helpers for the buffer FIFO and its storage array.
// The buffer stage downstream uses the same word width and depth defaults.
package buffer_fifo_pkg;

    localparam int BUF_DATA_WIDTH = 8;
    localparam int BUF_DEPTH      = 4;
    localparam int BUF_ADDR_WIDTH = $clog2(BUF_DEPTH);

    // Encoded as {push, pop} so the pair of handshake fires maps directly onto it.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/buffer_fifo_if.sv
// Producer/consumer handshake bundle for buffer_fifo.
// The FIFO takes the slave view; the surrounding logic (or bench) takes the master view.
interface buffer_fifo_if
    import buffer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = BUF_DATA_WIDTH,
    parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );

endinterface

// File: rtl/buffer_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
// Latency: write visible on rdata the cycle after the edge; read is combinational.
// Backpressure: none; the owner gates we.
module buffer_mem
    import buffer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = BUF_DATA_WIDTH,
    parameter int DEPTH      = BUF_DEPTH,
    parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Cleared on reset so the fall-through output is deterministic while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/buffer_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, feeding the buffer stage.
// Latency: a word pushed at edge N is on out_data with out_valid=1 right after edge N.
// Backpressure: in_ready drops only when full, from registered count, never from out_ready.
module buffer_fifo
    import buffer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = BUF_DATA_WIDTH,
    parameter int DEPTH      = BUF_DEPTH,
    parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    buffer_fifo_if.slave    bus
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  push;
    logic                  pop;
    fifo_op_e              op;

    // Full/empty come from the occupancy count alone; pointers wrap freely.
    assign bus.in_ready  = (count_q != FULL_COUNT);
    assign bus.out_valid = (count_q != '0);
    assign bus.count     = count_q;

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    assign op   = fifo_op(push, pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (op)
                OP_PUSH: count_q <= count_q + 1'b1;
                OP_POP:  count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    buffer_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (bus.out_data)
    );

endmodule
